// File: rtl/ysyx_24110006_axi_pkg.sv
// Shared constants and FSM state types for the AXI4 1-to-N demultiplexer.
package ysyx_24110006_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned DEF_NSLV = 3;
    localparam logic [DEF_NSLV*32-1:0] DEF_SLV_BASE = {32'h0200_0000, 32'ha000_03f8, 32'h8000_0000};
    localparam logic [DEF_NSLV*32-1:0] DEF_SLV_MASK = {32'hffff_fff8, 32'hffff_ffff, 32'hf800_0000};

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA,
        R_ERR
    } rstate_e;

    typedef enum logic [2:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_RESP,
        W_ERR_DATA,
        W_ERR_RESP
    } wstate_e;

endpackage

// File: rtl/ysyx_24110006_addr_decode.sv
// Combinational address decoder: one-hot select of the lowest matching slave, or miss.
module ysyx_24110006_addr_decode
    import ysyx_24110006_axi_pkg::*;
#(
    parameter int unsigned NSLV = DEF_NSLV,
    parameter logic [NSLV*32-1:0] SLV_BASE = DEF_SLV_BASE,
    parameter logic [NSLV*32-1:0] SLV_MASK = DEF_SLV_MASK
)(
    input  logic [31:0]     i_addr,
    output logic [NSLV-1:0] o_sel,
    output logic            o_miss
);

    logic [NSLV-1:0] w_hit;

    always_comb begin
        w_hit = '0;
        for (int unsigned k = 0; k < NSLV; k++) begin
            w_hit[k] = ((i_addr & SLV_MASK[k*32 +: 32]) == SLV_BASE[k*32 +: 32]);
        end
    end

    // Isolate the lowest set bit so overlapping windows resolve to the lowest index.
    assign o_sel  = w_hit & (~w_hit + NSLV'(1));
    assign o_miss = ~|w_hit;

endmodule

// File: rtl/ysyx_24110006_axi_demux.sv
// AXI4 1-to-N demultiplexer: independent read/write FSMs, one outstanding burst per direction.
module ysyx_24110006_axi_demux
    import ysyx_24110006_axi_pkg::*;
#(
    parameter int unsigned NSLV = DEF_NSLV,
    parameter logic [NSLV*32-1:0] SLV_BASE = DEF_SLV_BASE,
    parameter logic [NSLV*32-1:0] SLV_MASK = DEF_SLV_MASK,
    parameter int unsigned IDW = 4
)(
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic [31:0]          i_axi_araddr,
    input  logic                 i_axi_arvalid,
    input  logic [IDW-1:0]       i_axi_arid,
    input  logic [7:0]           i_axi_arlen,
    input  logic [2:0]           i_axi_arsize,
    input  logic [1:0]           i_axi_arburst,
    output logic                 o_axi_arready,
    output logic [31:0]          o_axi_rdata,
    output logic                 o_axi_rvalid,
    output logic [1:0]           o_axi_rresp,
    output logic [IDW-1:0]       o_axi_rid,
    output logic                 o_axi_rlast,
    input  logic                 i_axi_rready,
    input  logic [31:0]          i_axi_awaddr,
    input  logic                 i_axi_awvalid,
    input  logic [IDW-1:0]       i_axi_awid,
    input  logic [7:0]           i_axi_awlen,
    input  logic [2:0]           i_axi_awsize,
    input  logic [1:0]           i_axi_awburst,
    output logic                 o_axi_awready,
    input  logic [31:0]          i_axi_wdata,
    input  logic [3:0]           i_axi_wstrb,
    input  logic                 i_axi_wvalid,
    input  logic                 i_axi_wlast,
    output logic                 o_axi_wready,
    output logic                 o_axi_bvalid,
    output logic [1:0]           o_axi_bresp,
    output logic [IDW-1:0]       o_axi_bid,
    input  logic                 i_axi_bready,
    output logic [NSLV*32-1:0]   o_s_araddr,
    output logic [NSLV-1:0]      o_s_arvalid,
    output logic [NSLV*IDW-1:0]  o_s_arid,
    output logic [NSLV*8-1:0]    o_s_arlen,
    output logic [NSLV*3-1:0]    o_s_arsize,
    output logic [NSLV*2-1:0]    o_s_arburst,
    input  logic [NSLV-1:0]      i_s_arready,
    input  logic [NSLV*32-1:0]   i_s_rdata,
    input  logic [NSLV-1:0]      i_s_rvalid,
    input  logic [NSLV*2-1:0]    i_s_rresp,
    input  logic [NSLV*IDW-1:0]  i_s_rid,
    input  logic [NSLV-1:0]      i_s_rlast,
    output logic [NSLV-1:0]      o_s_rready,
    output logic [NSLV*32-1:0]   o_s_awaddr,
    output logic [NSLV-1:0]      o_s_awvalid,
    output logic [NSLV*IDW-1:0]  o_s_awid,
    output logic [NSLV*8-1:0]    o_s_awlen,
    output logic [NSLV*3-1:0]    o_s_awsize,
    output logic [NSLV*2-1:0]    o_s_awburst,
    input  logic [NSLV-1:0]      i_s_awready,
    output logic [NSLV*32-1:0]   o_s_wdata,
    output logic [NSLV*4-1:0]    o_s_wstrb,
    output logic [NSLV-1:0]      o_s_wvalid,
    output logic [NSLV-1:0]      o_s_wlast,
    input  logic [NSLV-1:0]      i_s_wready,
    input  logic [NSLV-1:0]      i_s_bvalid,
    input  logic [NSLV*2-1:0]    i_s_bresp,
    input  logic [NSLV*IDW-1:0]  i_s_bid,
    output logic [NSLV-1:0]      o_s_bready
);

    rstate_e          r_rstate;
    logic [NSLV-1:0]  r_rsel;
    logic [31:0]      r_araddr;
    logic [IDW-1:0]   r_arid;
    logic [7:0]       r_arlen;
    logic [2:0]       r_arsize;
    logic [1:0]       r_arburst;
    logic [7:0]       r_rcnt;

    wstate_e          r_wstate;
    logic [NSLV-1:0]  r_wsel;
    logic [31:0]      r_awaddr;
    logic [IDW-1:0]   r_awid;
    logic [7:0]       r_awlen;
    logic [2:0]       r_awsize;
    logic [1:0]       r_awburst;

    logic [NSLV-1:0]  w_ar_sel;
    logic             w_ar_miss;
    logic [NSLV-1:0]  w_aw_sel;
    logic             w_aw_miss;

    ysyx_24110006_addr_decode #(.NSLV(NSLV), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)) u_ar_dec (
        .i_addr (i_axi_araddr),
        .o_sel  (w_ar_sel),
        .o_miss (w_ar_miss)
    );

    ysyx_24110006_addr_decode #(.NSLV(NSLV), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)) u_aw_dec (
        .i_addr (i_axi_awaddr),
        .o_sel  (w_aw_sel),
        .o_miss (w_aw_miss)
    );

    // Read FSM: latch AR with its decode, then forward or synthesize DECERR beats.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rstate  <= R_IDLE;
            r_rsel    <= '0;
            r_araddr  <= '0;
            r_arid    <= '0;
            r_arlen   <= '0;
            r_arsize  <= '0;
            r_arburst <= '0;
            r_rcnt    <= '0;
        end else begin
            unique case (r_rstate)
                R_IDLE: if (i_axi_arvalid) begin
                    r_araddr  <= i_axi_araddr;
                    r_arid    <= i_axi_arid;
                    r_arlen   <= i_axi_arlen;
                    r_arsize  <= i_axi_arsize;
                    r_arburst <= i_axi_arburst;
                    r_rsel    <= w_ar_sel;
                    r_rcnt    <= '0;
                    r_rstate  <= w_ar_miss ? R_ERR : R_ADDR;
                end
                R_ADDR: if (|(i_s_arready & r_rsel)) r_rstate <= R_DATA;
                R_DATA: if (o_axi_rvalid && i_axi_rready && o_axi_rlast) r_rstate <= R_IDLE;
                R_ERR: if (i_axi_rready) begin
                    if (r_rcnt == r_arlen) r_rstate <= R_IDLE;
                    else                   r_rcnt   <= r_rcnt + 8'd1;
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    always_comb begin
        o_axi_arready = i_reset_n && (r_rstate == R_IDLE);
        o_axi_rvalid  = 1'b0;
        o_axi_rdata   = '0;
        o_axi_rresp   = RESP_OKAY;
        o_axi_rid     = '0;
        o_axi_rlast   = 1'b0;
        o_s_araddr    = '0;
        o_s_arvalid   = '0;
        o_s_arid      = '0;
        o_s_arlen     = '0;
        o_s_arsize    = '0;
        o_s_arburst   = '0;
        o_s_rready    = '0;
        for (int unsigned k = 0; k < NSLV; k++) begin
            if (r_rsel[k] && r_rstate == R_ADDR) begin
                o_s_arvalid[k]            = 1'b1;
                o_s_araddr[k*32 +: 32]    = r_araddr;
                o_s_arid[k*IDW +: IDW]    = r_arid;
                o_s_arlen[k*8 +: 8]       = r_arlen;
                o_s_arsize[k*3 +: 3]      = r_arsize;
                o_s_arburst[k*2 +: 2]     = r_arburst;
            end
            if (r_rsel[k] && r_rstate == R_DATA) begin
                o_s_rready[k] = i_axi_rready;
                o_axi_rvalid  = i_s_rvalid[k];
                o_axi_rdata   = i_s_rdata[k*32 +: 32];
                o_axi_rresp   = i_s_rresp[k*2 +: 2];
                o_axi_rid     = i_s_rid[k*IDW +: IDW];
                o_axi_rlast   = i_s_rlast[k];
            end
        end
        if (r_rstate == R_ERR) begin
            o_axi_rvalid = 1'b1;
            o_axi_rresp  = RESP_DECERR;
            o_axi_rid    = r_arid;
            o_axi_rlast  = (r_rcnt == r_arlen);
        end
    end

    // Write FSM: latch AW with its decode; misses swallow W and answer DECERR.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wstate  <= W_IDLE;
            r_wsel    <= '0;
            r_awaddr  <= '0;
            r_awid    <= '0;
            r_awlen   <= '0;
            r_awsize  <= '0;
            r_awburst <= '0;
        end else begin
            unique case (r_wstate)
                W_IDLE: if (i_axi_awvalid) begin
                    r_awaddr  <= i_axi_awaddr;
                    r_awid    <= i_axi_awid;
                    r_awlen   <= i_axi_awlen;
                    r_awsize  <= i_axi_awsize;
                    r_awburst <= i_axi_awburst;
                    r_wsel    <= w_aw_sel;
                    r_wstate  <= w_aw_miss ? W_ERR_DATA : W_ADDR;
                end
                W_ADDR:     if (|(i_s_awready & r_wsel)) r_wstate <= W_DATA;
                W_DATA:     if (i_axi_wvalid && o_axi_wready && i_axi_wlast) r_wstate <= W_RESP;
                W_RESP:     if (o_axi_bvalid && i_axi_bready) r_wstate <= W_IDLE;
                W_ERR_DATA: if (i_axi_wvalid && i_axi_wlast) r_wstate <= W_ERR_RESP;
                W_ERR_RESP: if (i_axi_bready) r_wstate <= W_IDLE;
                default:    r_wstate <= W_IDLE;
            endcase
        end
    end

    always_comb begin
        o_axi_awready = i_reset_n && (r_wstate == W_IDLE);
        o_axi_wready  = 1'b0;
        o_axi_bvalid  = 1'b0;
        o_axi_bresp   = RESP_OKAY;
        o_axi_bid     = '0;
        o_s_awaddr    = '0;
        o_s_awvalid   = '0;
        o_s_awid      = '0;
        o_s_awlen     = '0;
        o_s_awsize    = '0;
        o_s_awburst   = '0;
        o_s_wdata     = '0;
        o_s_wstrb     = '0;
        o_s_wvalid    = '0;
        o_s_wlast     = '0;
        o_s_bready    = '0;
        for (int unsigned k = 0; k < NSLV; k++) begin
            if (r_wsel[k] && r_wstate == W_ADDR) begin
                o_s_awvalid[k]            = 1'b1;
                o_s_awaddr[k*32 +: 32]    = r_awaddr;
                o_s_awid[k*IDW +: IDW]    = r_awid;
                o_s_awlen[k*8 +: 8]       = r_awlen;
                o_s_awsize[k*3 +: 3]      = r_awsize;
                o_s_awburst[k*2 +: 2]     = r_awburst;
            end
            if (r_wsel[k] && r_wstate == W_DATA) begin
                o_s_wvalid[k]          = i_axi_wvalid;
                o_s_wdata[k*32 +: 32]  = i_axi_wdata;
                o_s_wstrb[k*4 +: 4]    = i_axi_wstrb;
                o_s_wlast[k]           = i_axi_wlast;
                o_axi_wready           = i_s_wready[k];
            end
            if (r_wsel[k] && r_wstate == W_RESP) begin
                o_s_bready[k] = i_axi_bready;
                o_axi_bvalid  = i_s_bvalid[k];
                o_axi_bresp   = i_s_bresp[k*2 +: 2];
                o_axi_bid     = i_s_bid[k*IDW +: IDW];
            end
        end
        if (r_wstate == W_ERR_DATA) o_axi_wready = 1'b1;
        if (r_wstate == W_ERR_RESP) begin
            o_axi_bvalid = 1'b1;
            o_axi_bresp  = RESP_DECERR;
            o_axi_bid    = r_awid;
        end
    end

endmodule

// File: tb/tb_ysyx_24110006_axi_demux.sv
// Randomized bench for the AXI demux: the bench plays master and all slaves, checking against a decode model.
module tb_ysyx_24110006_axi_demux;

    localparam int NS  = 3;
    localparam int IDW = 4;

    logic i_clock, i_reset_n;
    logic [31:0] i_axi_araddr;  logic i_axi_arvalid; logic [IDW-1:0] i_axi_arid;
    logic [7:0]  i_axi_arlen;   logic [2:0] i_axi_arsize; logic [1:0] i_axi_arburst;
    logic o_axi_arready;
    logic [31:0] o_axi_rdata; logic o_axi_rvalid; logic [1:0] o_axi_rresp;
    logic [IDW-1:0] o_axi_rid; logic o_axi_rlast; logic i_axi_rready;
    logic [31:0] i_axi_awaddr;  logic i_axi_awvalid; logic [IDW-1:0] i_axi_awid;
    logic [7:0]  i_axi_awlen;   logic [2:0] i_axi_awsize; logic [1:0] i_axi_awburst;
    logic o_axi_awready;
    logic [31:0] i_axi_wdata; logic [3:0] i_axi_wstrb; logic i_axi_wvalid, i_axi_wlast, o_axi_wready;
    logic o_axi_bvalid; logic [1:0] o_axi_bresp; logic [IDW-1:0] o_axi_bid; logic i_axi_bready;
    logic [NS*32-1:0] o_s_araddr; logic [NS-1:0] o_s_arvalid; logic [NS*IDW-1:0] o_s_arid;
    logic [NS*8-1:0] o_s_arlen; logic [NS*3-1:0] o_s_arsize; logic [NS*2-1:0] o_s_arburst;
    logic [NS-1:0] i_s_arready;
    logic [NS*32-1:0] i_s_rdata; logic [NS-1:0] i_s_rvalid; logic [NS*2-1:0] i_s_rresp;
    logic [NS*IDW-1:0] i_s_rid; logic [NS-1:0] i_s_rlast; logic [NS-1:0] o_s_rready;
    logic [NS*32-1:0] o_s_awaddr; logic [NS-1:0] o_s_awvalid; logic [NS*IDW-1:0] o_s_awid;
    logic [NS*8-1:0] o_s_awlen; logic [NS*3-1:0] o_s_awsize; logic [NS*2-1:0] o_s_awburst;
    logic [NS-1:0] i_s_awready;
    logic [NS*32-1:0] o_s_wdata; logic [NS*4-1:0] o_s_wstrb; logic [NS-1:0] o_s_wvalid, o_s_wlast;
    logic [NS-1:0] i_s_wready;
    logic [NS-1:0] i_s_bvalid; logic [NS*2-1:0] i_s_bresp; logic [NS*IDW-1:0] i_s_bid;
    logic [NS-1:0] o_s_bready;

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_24110006_axi_demux #(.NSLV(NS), .IDW(IDW)) dut (
        .i_clock(i_clock), .i_reset_n(i_reset_n),
        .i_axi_araddr(i_axi_araddr), .i_axi_arvalid(i_axi_arvalid), .i_axi_arid(i_axi_arid),
        .i_axi_arlen(i_axi_arlen), .i_axi_arsize(i_axi_arsize), .i_axi_arburst(i_axi_arburst),
        .o_axi_arready(o_axi_arready),
        .o_axi_rdata(o_axi_rdata), .o_axi_rvalid(o_axi_rvalid), .o_axi_rresp(o_axi_rresp),
        .o_axi_rid(o_axi_rid), .o_axi_rlast(o_axi_rlast), .i_axi_rready(i_axi_rready),
        .i_axi_awaddr(i_axi_awaddr), .i_axi_awvalid(i_axi_awvalid), .i_axi_awid(i_axi_awid),
        .i_axi_awlen(i_axi_awlen), .i_axi_awsize(i_axi_awsize), .i_axi_awburst(i_axi_awburst),
        .o_axi_awready(o_axi_awready),
        .i_axi_wdata(i_axi_wdata), .i_axi_wstrb(i_axi_wstrb), .i_axi_wvalid(i_axi_wvalid),
        .i_axi_wlast(i_axi_wlast), .o_axi_wready(o_axi_wready),
        .o_axi_bvalid(o_axi_bvalid), .o_axi_bresp(o_axi_bresp), .o_axi_bid(o_axi_bid),
        .i_axi_bready(i_axi_bready),
        .o_s_araddr(o_s_araddr), .o_s_arvalid(o_s_arvalid), .o_s_arid(o_s_arid),
        .o_s_arlen(o_s_arlen), .o_s_arsize(o_s_arsize), .o_s_arburst(o_s_arburst),
        .i_s_arready(i_s_arready),
        .i_s_rdata(i_s_rdata), .i_s_rvalid(i_s_rvalid), .i_s_rresp(i_s_rresp),
        .i_s_rid(i_s_rid), .i_s_rlast(i_s_rlast), .o_s_rready(o_s_rready),
        .o_s_awaddr(o_s_awaddr), .o_s_awvalid(o_s_awvalid), .o_s_awid(o_s_awid),
        .o_s_awlen(o_s_awlen), .o_s_awsize(o_s_awsize), .o_s_awburst(o_s_awburst),
        .i_s_awready(i_s_awready),
        .o_s_wdata(o_s_wdata), .o_s_wstrb(o_s_wstrb), .o_s_wvalid(o_s_wvalid),
        .o_s_wlast(o_s_wlast), .i_s_wready(i_s_wready),
        .i_s_bvalid(i_s_bvalid), .i_s_bresp(i_s_bresp), .i_s_bid(i_s_bid),
        .o_s_bready(o_s_bready)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Address map model: lowest slave whose masked address equals its base; -1 on miss.
    function automatic int ref_decode(input logic [31:0] a);
        logic [31:0] base [NS];
        logic [31:0] mask [NS];
        base = '{32'h8000_0000, 32'ha000_03f8, 32'h0200_0000};
        mask = '{32'hf800_0000, 32'hffff_ffff, 32'hffff_fff8};
        for (int k = 0; k < NS; k++) if ((a & mask[k]) == base[k]) return k;
        return -1;
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return 32'h8000_0000 | ($urandom & 32'h07ff_fffc);
            1:       return 32'ha000_03f8;
            2:       return 32'h0200_0000 | 32'($urandom_range(0, 7));
            default: return 32'h4000_0000 | ($urandom & 32'h0fff_fffc);
        endcase
    endfunction

    task automatic do_read(input logic [31:0] addr, input logic [IDW-1:0] id,
                           input logic [7:0] len, input bit poke);
        int k, n, b, cyc;
        logic [NS-1:0] oh;
        logic [NS*32-1:0] ev32;
        logic sv, rr;
        logic [31:0] d;
        logic [1:0] rs;
        logic [IDW-1:0] sid;
        k = ref_decode(addr);
        oh = '0;
        if (k >= 0) oh[k] = 1'b1;
        @(negedge i_clock);
        i_axi_araddr = addr; i_axi_arid = id; i_axi_arlen = len;
        i_axi_arsize = 3'd2; i_axi_arburst = 2'b01; i_axi_arvalid = 1'b1;
        #1 chk("ar_accept_ready", o_axi_arready, 1'b1);
        @(negedge i_clock);
        i_axi_arvalid = 1'b0;
        i_axi_araddr  = poke ? 32'h8000_0000 : $urandom;
        b = 0; cyc = 0;
        if (k >= 0) begin
            ev32 = '0; ev32[k*32 +: 32] = addr;
            n = $urandom_range(0, 2);
            for (int c = 0; c <= n; c++) begin
                i_s_arready = NS'($urandom) & ~oh;
                if (c == n) i_s_arready = i_s_arready | oh;
                #1;
                chk("s_arvalid", o_s_arvalid, oh);
                chk("s_araddr", o_s_araddr, ev32);
                chk("s_arid", o_s_arid[k*IDW +: IDW], id);
                chk("s_arlen", o_s_arlen[k*8 +: 8], len);
                @(negedge i_clock);
            end
            i_s_arready = '0;
            while (b <= int'(len)) begin
                sv = ($urandom_range(0, 3) != 0) || cyc >= 3;
                rr = ($urandom_range(0, 3) != 0) || cyc >= 3;
                d = $urandom; rs = $urandom_range(0, 1) ? 2'b10 : 2'b00; sid = IDW'($urandom);
                i_s_rvalid = NS'($urandom); i_s_rdata = {$urandom, $urandom, $urandom};
                i_s_rresp = (NS*2)'($urandom); i_s_rid = (NS*IDW)'($urandom); i_s_rlast = NS'($urandom);
                i_s_rvalid[k] = sv; i_s_rdata[k*32 +: 32] = d; i_s_rresp[k*2 +: 2] = rs;
                i_s_rid[k*IDW +: IDW] = sid; i_s_rlast[k] = (b == int'(len));
                i_axi_rready = rr;
                #1;
                chk("rvalid", o_axi_rvalid, sv);
                if (sv) begin
                    chk("rdata", o_axi_rdata, d);
                    chk("rresp", o_axi_rresp, rs);
                    chk("rid", o_axi_rid, sid);
                    chk("rlast", o_axi_rlast, (b == int'(len)));
                end
                chk("s_rready", o_s_rready, rr ? oh : '0);
                if (sv && rr) begin b++; cyc = 0; end else cyc++;
                @(negedge i_clock);
            end
            i_s_rvalid = '0; i_s_rlast = '0;
        end else begin
            while (b <= int'(len)) begin
                rr = ($urandom_range(0, 2) != 0) || cyc >= 3;
                i_axi_rready = rr;
                #1;
                chk("err_rvalid", o_axi_rvalid, 1'b1);
                chk("err_rdata", o_axi_rdata, 32'h0);
                chk("err_rresp", o_axi_rresp, 2'b11);
                chk("err_rid", o_axi_rid, id);
                chk("err_rlast", o_axi_rlast, (b == int'(len)));
                chk("err_s_arvalid", o_s_arvalid, '0);
                if (rr) begin b++; cyc = 0; end else cyc++;
                @(negedge i_clock);
            end
        end
        i_axi_rready = 1'b0;
        #1;
        chk("r_done_rvalid", o_axi_rvalid, 1'b0);
        chk("r_done_arready", o_axi_arready, 1'b1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [IDW-1:0] id, input logic [7:0] len);
        int k, n, b, cyc;
        logic [NS-1:0] oh;
        logic [NS*32-1:0] ev32;
        logic wv, sw, sb, br, done;
        logic [31:0] d;
        logic [3:0] st;
        logic [1:0] rs;
        logic [IDW-1:0] sid;
        k = ref_decode(addr);
        oh = '0;
        if (k >= 0) oh[k] = 1'b1;
        @(negedge i_clock);
        i_axi_awaddr = addr; i_axi_awid = id; i_axi_awlen = len;
        i_axi_awsize = 3'd2; i_axi_awburst = 2'b01; i_axi_awvalid = 1'b1;
        #1;
        chk("aw_accept_ready", o_axi_awready, 1'b1);
        chk("w_idle_wready", o_axi_wready, 1'b0);
        @(negedge i_clock);
        i_axi_awvalid = 1'b0;
        i_axi_awaddr  = $urandom;
        b = 0; cyc = 0;
        if (k >= 0) begin
            ev32 = '0; ev32[k*32 +: 32] = addr;
            n = $urandom_range(0, 2);
            for (int c = 0; c <= n; c++) begin
                i_s_awready = NS'($urandom) & ~oh;
                if (c == n) i_s_awready = i_s_awready | oh;
                i_axi_wvalid = 1'b1; i_axi_wdata = $urandom;
                #1;
                chk("s_awvalid", o_s_awvalid, oh);
                chk("s_awaddr", o_s_awaddr, ev32);
                chk("s_awid", o_s_awid[k*IDW +: IDW], id);
                chk("w_addr_wready", o_axi_wready, 1'b0);
                chk("w_addr_s_wvalid", o_s_wvalid, '0);
                @(negedge i_clock);
            end
            i_s_awready = '0;
            while (b <= int'(len)) begin
                wv = ($urandom_range(0, 3) != 0) || cyc >= 3;
                sw = ($urandom_range(0, 3) != 0) || cyc >= 3;
                d = $urandom; st = 4'($urandom);
                i_axi_wvalid = wv; i_axi_wdata = d; i_axi_wstrb = st; i_axi_wlast = (b == int'(len));
                i_s_wready = NS'($urandom); i_s_wready[k] = sw;
                #1;
                ev32 = '0; ev32[k*32 +: 32] = d;
                chk("s_wdata", o_s_wdata, ev32);
                chk("s_wvalid", o_s_wvalid, wv ? oh : '0);
                chk("s_wstrb", o_s_wstrb[k*4 +: 4], st);
                chk("s_wlast", o_s_wlast[k], (b == int'(len)));
                chk("wready", o_axi_wready, sw);
                if (wv && sw) begin b++; cyc = 0; end else cyc++;
                @(negedge i_clock);
            end
            i_axi_wvalid = 1'b0; i_axi_wlast = 1'b0; i_s_wready = '0;
            done = 1'b0; cyc = 0;
            while (!done) begin
                sb = ($urandom_range(0, 2) != 0) || cyc >= 3;
                br = ($urandom_range(0, 2) != 0) || cyc >= 3;
                rs = $urandom_range(0, 1) ? 2'b10 : 2'b00; sid = IDW'($urandom);
                i_s_bvalid = NS'($urandom); i_s_bresp = (NS*2)'($urandom); i_s_bid = (NS*IDW)'($urandom);
                i_s_bvalid[k] = sb; i_s_bresp[k*2 +: 2] = rs; i_s_bid[k*IDW +: IDW] = sid;
                i_axi_bready = br;
                #1;
                chk("bvalid", o_axi_bvalid, sb);
                if (sb) begin
                    chk("bresp", o_axi_bresp, rs);
                    chk("bid", o_axi_bid, sid);
                end
                chk("s_bready", o_s_bready, br ? oh : '0);
                done = sb && br; cyc++;
                @(negedge i_clock);
            end
            i_s_bvalid = '0;
        end else begin
            while (b <= int'(len)) begin
                wv = ($urandom_range(0, 2) != 0) || cyc >= 3;
                i_axi_wvalid = wv; i_axi_wdata = $urandom; i_axi_wlast = (b == int'(len));
                i_s_wready = NS'($urandom);
                #1;
                chk("err_wready", o_axi_wready, 1'b1);
                chk("err_s_wvalid", o_s_wvalid, '0);
                chk("err_s_awvalid", o_s_awvalid, '0);
                if (wv) begin b++; cyc = 0; end else cyc++;
                @(negedge i_clock);
            end
            i_axi_wvalid = 1'b0; i_axi_wlast = 1'b0; i_s_wready = '0;
            done = 1'b0; cyc = 0;
            while (!done) begin
                br = ($urandom_range(0, 2) != 0) || cyc >= 3;
                i_axi_bready = br;
                #1;
                chk("err_bvalid", o_axi_bvalid, 1'b1);
                chk("err_bresp", o_axi_bresp, 2'b11);
                chk("err_bid", o_axi_bid, id);
                chk("err_s_bready", o_s_bready, '0);
                done = br; cyc++;
                @(negedge i_clock);
            end
        end
        i_axi_bready = 1'b0;
        #1;
        chk("w_done_bvalid", o_axi_bvalid, 1'b0);
        chk("w_done_awready", o_axi_awready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, wa;
        logic [IDW-1:0] rid_v, wid_v;
        logic [7:0] rl, wl;
        bit pk;
        i_reset_n = 1'b0;
        i_axi_araddr = '0; i_axi_arvalid = 0; i_axi_arid = '0; i_axi_arlen = '0; i_axi_arsize = '0; i_axi_arburst = '0;
        i_axi_rready = 0;
        i_axi_awaddr = '0; i_axi_awvalid = 0; i_axi_awid = '0; i_axi_awlen = '0; i_axi_awsize = '0; i_axi_awburst = '0;
        i_axi_wdata = '0; i_axi_wstrb = '0; i_axi_wvalid = 0; i_axi_wlast = 0; i_axi_bready = 0;
        i_s_arready = '0; i_s_rdata = '0; i_s_rvalid = '0; i_s_rresp = '0; i_s_rid = '0; i_s_rlast = '0;
        i_s_awready = '0; i_s_wready = '0; i_s_bvalid = '0; i_s_bresp = '0; i_s_bid = '0;
        repeat (3) @(negedge i_clock);
        #1;
        chk("rst_arready", o_axi_arready, 1'b0);
        chk("rst_awready", o_axi_awready, 1'b0);
        chk("rst_rvalid", o_axi_rvalid, 1'b0);
        chk("rst_bvalid", o_axi_bvalid, 1'b0);
        chk("rst_wready", o_axi_wready, 1'b0);
        chk("rst_s_valids", {o_s_arvalid, o_s_awvalid, o_s_wvalid, o_s_rready, o_s_bready}, '0);
        @(negedge i_clock);
        i_reset_n = 1'b1;
        #1;
        chk("post_rst_arready", o_axi_arready, 1'b1);
        chk("post_rst_awready", o_axi_awready, 1'b1);

        do_read(32'h8000_0100, 4'd1, 8'd3, 1'b0);
        do_read(32'h0200_0004, 4'd2, 8'd2, 1'b1);
        do_read(32'h4000_0000, 4'd5, 8'd1, 1'b0);
        do_write(32'ha000_03f8, 4'd6, 8'd0);
        fork
            do_write(32'h1000_0000, 4'd3, 8'd2);
            do_read(32'h8000_0040, 4'd7, 8'd2, 1'b0);
        join
        fork
            do_write(32'h8000_0000, 4'd9, 8'd1);
            do_read(32'h8000_0008, 4'd4, 8'd1, 1'b0);
        join

        for (int t = 0; t < 40; t++) begin
            ra = rand_addr(); wa = rand_addr();
            rid_v = IDW'($urandom); wid_v = IDW'($urandom);
            rl = 8'($urandom_range(0, 3)); wl = 8'($urandom_range(0, 3));
            pk = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 2))
                0:       do_read(ra, rid_v, rl, pk);
                1:       do_write(wa, wid_v, wl);
                default: fork
                    do_read(ra, rid_v, rl, pk);
                    do_write(wa, wid_v, wl);
                join
            endcase
        end

        // Reset in the middle of a 4-beat read to slave0.
        @(negedge i_clock);
        i_axi_araddr = 32'h8000_0100; i_axi_arlen = 8'd3; i_axi_arid = 4'd2; i_axi_arvalid = 1'b1;
        @(negedge i_clock);
        i_axi_arvalid = 1'b0; i_s_arready = 3'b001;
        @(negedge i_clock);
        i_s_arready = '0; i_s_rvalid = 3'b001; i_s_rlast = '0; i_s_rdata = 96'h1234; i_axi_rready = 1'b1;
        @(negedge i_clock);
        #1 chk("mid_burst_rvalid", o_axi_rvalid, 1'b1);
        i_reset_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", o_axi_rvalid, 1'b0);
        chk("mid_rst_arready", o_axi_arready, 1'b0);
        chk("mid_rst_awready", o_axi_awready, 1'b0);
        chk("mid_rst_s_rready", o_s_rready, '0);
        chk("mid_rst_s_arvalid", o_s_arvalid, '0);
        @(negedge i_clock);
        i_s_rvalid = '0; i_s_rdata = '0; i_axi_rready = 1'b0;
        i_reset_n = 1'b1;
        #1;
        chk("rel_arready", o_axi_arready, 1'b1);
        chk("rel_awready", o_axi_awready, 1'b1);
        do_read(32'h8000_0000, 4'd8, 8'd3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_24110006_axi_demux.md
YSYX_24110006_AXI_DEMUX -- requirements
Module: ysyx_24110006_axi_demux

Interface
REQ-001 SHALL have parameter NSLV, default 3, meaning the number of downstream AXI4 slave ports (1..8).
REQ-002 SHALL have parameter SLV_BASE, default {32'h0200_0000, 32'ha000_03f8, 32'h8000_0000} (slave2..slave0), meaning the per-slave base address.
REQ-003 SHALL have parameter SLV_MASK, default {32'hffff_fff8, 32'hffff_ffff, 32'hf800_0000}, meaning the per-slave decode mask.
REQ-004 SHALL have parameter IDW, default 4, meaning the ID width.
REQ-005 i_clock  in  1  single clock; all state updates on its rising edge.
REQ-006 i_reset_n  in  1  reset, asynchronous and active-low.
REQ-007 i_axi_ar{addr,valid,id,len,size,burst} in / o_axi_arready out  32/1/IDW/8/3/2 / 1  upstream AR channel.
REQ-008 o_axi_r{data,valid,resp,id,last} out / i_axi_rready in  32/1/2/IDW/1 / 1  upstream R channel.
REQ-009 i_axi_aw{addr,valid,id,len,size,burst} in / o_axi_awready out  32/1/IDW/8/3/2 / 1  upstream AW channel.
REQ-010 i_axi_w{data,strb,valid,last} in / o_axi_wready out  32/4/1/1 / 1  upstream W channel.
REQ-011 o_axi_b{valid,resp,id} out / i_axi_bready in  1/2/IDW / 1  upstream B channel.
REQ-012 o_s_*/i_s_*  out/in  NSLV×(per-channel width)  all five downstream AXI4 channels for every slave, packed as vectors, slave k in slice k.

Function
REQ-013 Decode SHALL be: slave k hits when (addr & SLV_MASK[k]) == SLV_BASE[k]; lowest hitting k wins; no hit is a decode error.
REQ-014 Read FSM SHALL have states R_IDLE, R_ADDR, R_DATA, R_ERR; write FSM W_IDLE, W_ADDR, W_DATA, W_RESP, W_ERR_DATA, W_ERR_RESP; the two FSMs are independent and may run concurrently.
REQ-015 In R_IDLE, o_axi_arready SHALL be 1; on arvalid, AR fields and the decode result SHALL be registered; go to R_ADDR on a hit, R_ERR on a miss.
REQ-016 In R_ADDR, the registered AR SHALL drive only the selected slave with arvalid=1; on that slave's arready go to R_DATA (AR reaches the slave 1 cycle after upstream acceptance).
REQ-017 In R_DATA, R SHALL pass combinationally from the selected slave and rready only to it; on rvalid&rready&rlast return to R_IDLE.
REQ-018 R_ERR SHALL emit arlen+1 beats, rdata=0, rresp=2'b11, rid=latched ID, rlast on the final beat only, advancing per rready; then R_IDLE.
REQ-019 In W_IDLE, o_axi_awready SHALL be 1; AW is registered with its decode; go to W_ADDR on a hit, W_ERR_DATA on a miss.
REQ-020 W_ADDR SHALL forward the registered AW to the selected slave until awready, then W_DATA; o_axi_wready=0 in W_IDLE and W_ADDR.
REQ-021 W_DATA SHALL pass W to the selected slave until wvalid&wready&wlast, then W_RESP; W_RESP passes B until bvalid&bready, then W_IDLE.
REQ-022 W_ERR_DATA SHALL hold wready=1 and discard data until wlast; W_ERR_RESP drives bvalid=1, bresp=2'b11, bid=latched ID until bready.
REQ-023 Only one outstanding transaction per direction SHALL exist; the slave select SHALL remain stable from acceptance to the final handshake, whatever the live address inputs do.
REQ-024 Unselected slaves SHALL see valid/ready=0 and payloads=0; rlast/rid from the selected slave pass unmodified.
REQ-025 A read and a write to the same slave simultaneously SHALL both proceed; ordering across directions is not guaranteed.

Reset
REQ-026 i_reset_n low SHALL immediately force both FSMs to IDLE, all downstream valid/ready outputs to 0, o_axi_rvalid/bvalid/wready to 0, and arready/awready to 0 while asserted.
REQ-027 Reset mid-burst SHALL abandon the transaction; after release arready and awready are 1 on the first cycle.

Structure
REQ-028 Package ysyx_24110006_axi_pkg SHALL hold the RESP_OKAY/RESP_DECERR constants, the read and write state enums, and the default base/mask constants.
REQ-029 Sub-module ysyx_24110006_addr_decode SHALL implement REQ-013 combinationally (inputs: addr; outputs: one-hot select and miss), instanced once per direction.

Verification
REQ-030 AR 0x8000_0100, arlen=3 -> slave0 sees arvalid 1 cycle later, 4 R beats pass, rlast on beat 4, rresp=0.
REQ-031 AR 0x0200_0004 -> slave2 selected; live araddr changed to 0x8000_0000 mid-burst -> select unchanged.
REQ-032 AR 0x4000_0000, arlen=1, id=5 -> 2 beats rresp=2'b11, rid=5, rdata=0, rlast only on beat 2; no slave arvalid.
REQ-033 AW 0xa000_03f8 + W 0x41 strb 4'b0001 -> only slave1 sees AW/W; B from slave1 returned with its bid.
REQ-034 AW 0x1000_0000, awlen=2, id=3 -> 3 W beats absorbed, bresp=2'b11, bid=3; concurrent read to slave0 completes unaffected.
REQ-035 Reset asserted during beat 2 of a 4-beat read -> rvalid=0 same cycle; after release, new AR 0x8000_0000 completes normally.
